// File: rtl/store_load_buffer.sv
// -----------------------------------------------------------------------------
// store_load_buffer
//   In-order store buffer between the MEM stage and the data-cache port.
//   Stores retire from MEM in one cycle into a circular FIFO and drain to the
//   cache one at a time, oldest first. Younger loads to the same word get the
//   buffered data forwarded. A load the buffer can only partly supply is
//   flagged as a conflict so MEM stalls until the buffer drains.
//
//   Optional feature (macro STB_COALESCE_EN): a store to the same word as the
//   youngest entry merges into that entry instead of allocating a new one.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   st_valid/addr/data/mbe      store request from MEM
//   st_ready                    buffer can take a store (0 = stall MEM)
//   ld_valid/addr/mbe           load lookup from MEM
//   ld_hit, ld_data             all requested bytes forwarded, forwarded word
//   ld_conflict                 partial overlap, MEM must stall
//   dmem_busy                   load path owns the cache port this cycle
//   dmem_write/address/wdata/mbe write request built from the head entry
//   dmem_resp                   cache completed the current write
//   empty                       nothing buffered and no write in flight
// -----------------------------------------------------------------------------
module store_load_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_mbe,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_mbe,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_conflict,
  input  logic        dmem_busy,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic        dmem_resp,
  output logic        empty
);

  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

  logic [29:0]      addr_r [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [3:0]       mbe_r  [DEPTH];
  logic [PTR_W-1:0] head_r, tail_r;
  logic [PTR_W:0]   count_r, count_next_s;
  state_t           state_r, state_next_s;

  logic [PTR_W-1:0] young_idx_s;
  logic             merge_possible_s;
  logic             push_s, merge_s, pop_s;
  logic             found_s;
  logic [PTR_W-1:0] sel_idx_s;
  logic [3:0]       sel_cover_s;
  logic             unused_addr_lsb_s;

  // Byte offsets are irrelevant: everything works on whole words.
  assign unused_addr_lsb_s = ^{st_addr[1:0], ld_addr[1:0]};

  assign young_idx_s = tail_r - PTR_ONE;

`ifdef STB_COALESCE_EN
  // Merge into the youngest entry unless it is the head already being written.
  assign merge_possible_s = (count_r != CNT_ZERO) &&
                            (addr_r[young_idx_s] == st_addr[31:2]) &&
                            !((young_idx_s == head_r) && (state_r == ST_WRITE));
  assign st_ready = (count_r != CNT_FULL) | merge_possible_s;
`else
  assign merge_possible_s = 1'b0;
  assign st_ready = (count_r != CNT_FULL);
`endif

  assign merge_s = st_valid & st_ready & merge_possible_s;
  assign push_s  = st_valid & st_ready & ~merge_possible_s;
  assign pop_s   = (state_r == ST_WRITE) & dmem_resp;

  assign dmem_write   = (state_r == ST_WRITE);
  assign dmem_address = {addr_r[head_r], 2'b00};
  assign dmem_wdata   = data_r[head_r];
  assign dmem_mbe     = mbe_r[head_r];
  assign empty        = (count_r == CNT_ZERO) && (state_r == ST_IDLE);

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Drain FSM next state; a started write is never aborted by dmem_busy.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != CNT_ZERO) && !dmem_busy) state_next_s = ST_WRITE;
        else                                     state_next_s = ST_IDLE;
      end
      ST_WRITE: begin
        if (dmem_resp) begin
          if ((count_next_s != CNT_ZERO) && !dmem_busy) state_next_s = ST_WRITE;
          else                                          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Control state: pointers, occupancy and drain FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= CNT_ZERO;
      state_r <= ST_IDLE;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_ONE;
      if (pop_s)  head_r <= head_r + PTR_ONE;
      count_r <= count_next_s;
      state_r <= state_next_s;
    end
  end

  // Entry storage: allocate at the tail or merge bytes into the youngest entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_r[tail_r] <= st_addr[31:2];
      data_r[tail_r] <= st_data;
      mbe_r[tail_r]  <= st_mbe;
    end else if (merge_s) begin
      for (int b = 0; b < 4; b++) begin
        if (st_mbe[b]) data_r[young_idx_s][8*b +: 8] <= st_data[8*b +: 8];
      end
      mbe_r[young_idx_s] <= mbe_r[young_idx_s] | st_mbe;
    end
  end

  // Load lookup: first overlapping entry scanning from youngest to oldest.
  always_comb begin : lookup
    logic [PTR_W-1:0] idx_v;
    found_s   = 1'b0;
    sel_idx_s = '0;
    idx_v     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v = tail_r - PTR_W'(k + 1);
      if (!found_s && ((PTR_W+1)'(k) < count_r) &&
          (addr_r[idx_v] == ld_addr[31:2]) &&
          ((mbe_r[idx_v] & ld_mbe) != 4'b0000)) begin
        found_s   = 1'b1;
        sel_idx_s = idx_v;
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  assign sel_cover_s = mbe_r[sel_idx_s] & ld_mbe;
  assign ld_data     = data_r[sel_idx_s];
  assign ld_hit      = ld_valid & found_s & (sel_cover_s == ld_mbe);
  assign ld_conflict = ld_valid & found_s & (sel_cover_s != ld_mbe);

endmodule

// File: tb/tb_store_load_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_load_buffer
//   Directed stimulus with a scoreboard: stores push expected cache writes,
//   loads push expected lookup results; a monitor pops and compares whenever
//   the DUT completes a write or a load is presented.
// -----------------------------------------------------------------------------
module tb_store_load_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mbe;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_mbe;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        dmem_busy;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic        empty;

  logic        resp_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

`ifdef STB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mbe;
  } wr_t;

  typedef struct packed {
    logic        hit;
    logic        conf;
    logic [31:0] data;
  } ld_t;

  wr_t exp_wr[$];
  ld_t exp_ld[$];

  store_load_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_mbe(st_mbe),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mbe(ld_mbe),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
    .dmem_busy(dmem_busy), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_resp(dmem_resp),
    .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue a store and hold it until accepted; records the expected cache write.
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit merge);
    bit  accepted;
    wr_t t;
    accepted = 1'b0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_mbe = m;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (st_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    st_valid = 1'b0;
    chk("store_accepted", {31'b0, accepted}, 32'd1);
    if (merge && exp_wr.size() > 0) begin
      t = exp_wr.pop_back();
      t.data = (t.data & ~lane_mask(m)) | (d & lane_mask(m));
      t.mbe  = t.mbe | m;
      exp_wr.push_back(t);
    end else begin
      exp_wr.push_back('{addr: {a[31:2], 2'b00}, data: d, mbe: m});
    end
  endtask

  // Present a load for one cycle and record the expected lookup result.
  task automatic load(input logic [31:0] a, input logic [3:0] m,
                      input logic h, input logic c, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_mbe = m;
    exp_ld.push_back('{hit: h, conf: c, data: d});
    @(posedge clk);
    #2;
    ld_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (empty) begin
        seen = 1'b1;
        break;
      end
    end
    chk("drain_to_empty", {31'b0, seen}, 32'd1);
    step();
  endtask

  // Cache model: completes each write one cycle after it is presented.
  initial begin
    dmem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dmem_resp = resp_en & (dmem_write === 1'b1);
    end
  end

  // Monitor: compares completed writes and presented loads against the queues.
  initial begin
    wr_t w;
    ld_t l;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (dmem_write === 1'b1 && dmem_resp) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got write to %h, expected none", dmem_address);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", dmem_address, w.addr);
            chk("wr_mbe", {28'b0, dmem_mbe}, {28'b0, w.mbe});
            chk("wr_data", dmem_wdata & lane_mask(w.mbe), w.data & lane_mask(w.mbe));
          end
        end
        if (ld_valid) begin
          if (exp_ld.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: got load at %h, expected none", ld_addr);
          end else begin
            l = exp_ld.pop_front();
            chk("ld_hit", {31'b0, ld_hit}, {31'b0, l.hit});
            chk("ld_conflict", {31'b0, ld_conflict}, {31'b0, l.conf});
            if (l.hit) chk("ld_data", ld_data, l.data);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_mbe = 4'b0000;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_mbe = 4'b0000;
    dmem_busy = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_ld_hit", {31'b0, ld_hit}, 32'd0);
    chk("rst_ld_conflict", {31'b0, ld_conflict}, 32'd0);
    chk("rst_dmem_write", {31'b0, dmem_write}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    step();
    rst = 1'b0;
    resp_en = 1'b1;
    step();

    // Store to load forwarding, plus a miss to a neighbouring word
    dmem_busy = 1'b1;
    store(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    load(32'h0000_1000, 4'b0011, 1'b1, 1'b0, 32'hDEAD_BEEF);
    load(32'h0000_1004, 4'b0011, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("not_empty_busy", {31'b0, empty}, 32'd0);
    step();
    dmem_busy = 1'b0;
    wait_empty();

    // Partial overlap conflicts until drained, then misses
    dmem_busy = 1'b1;
    store(32'h0000_2000, 32'h0000_00AB, 4'b0001, 1'b0);
    load(32'h0000_2000, 4'b1111, 1'b0, 1'b1, 32'h0);
    load(32'h0000_2002, 4'b0001, 1'b1, 1'b0, 32'h0000_00AB);
    dmem_busy = 1'b0;
    wait_empty();
    load(32'h0000_2000, 4'b1111, 1'b0, 1'b0, 32'h0);

    // Youngest entry wins; drain stays in program order
    dmem_busy = 1'b1;
    store(32'h0000_3000, 32'h1111_1111, 4'b1111, 1'b0);
    store(32'h0000_3000, 32'h2222_2222, 4'b1111, COAL);
    load(32'h0000_3000, 4'b1111, 1'b1, 1'b0, 32'h2222_2222);
    load(32'h0000_3000, 4'b1000, 1'b1, 1'b0, 32'h2222_2222);
    dmem_busy = 1'b0;
    wait_empty();

    // Full buffer back-pressure; fifth store accepted once a slot frees
    dmem_busy = 1'b1;
    store(32'h0000_5000, 32'h5000_0000, 4'b1111, 1'b0);
    store(32'h0000_5004, 32'h5000_0004, 4'b1111, 1'b0);
    store(32'h0000_5008, 32'h5000_0008, 4'b1111, 1'b0);
    store(32'h0000_500C, 32'h5000_000C, 4'b1111, 1'b0);
    @(negedge clk);
    chk("full_st_ready", {31'b0, st_ready}, 32'd0);
    step();
    load(32'h0000_5000, 4'b1111, 1'b1, 1'b0, 32'h5000_0000);
    dmem_busy = 1'b0;
    store(32'h0000_5010, 32'h5000_0010, 4'b1111, 1'b0);
    wait_empty();

    // Same-word stores: coalesced when enabled, otherwise two entries
    dmem_busy = 1'b1;
    store(32'h0000_4000, 32'h0000_00AA, 4'b0001, 1'b0);
    store(32'h0000_4000, 32'h00BB_0000, 4'b0100, COAL);
`ifdef STB_COALESCE_EN
    load(32'h0000_4000, 4'b0101, 1'b1, 1'b0, 32'h00BB_00AA);
`else
    load(32'h0000_4000, 4'b0101, 1'b0, 1'b1, 32'h0);
    load(32'h0000_4000, 4'b0100, 1'b1, 1'b0, 32'h00BB_0000);
`endif
    dmem_busy = 1'b0;
    wait_empty();

    // Reset during an in-flight write discards everything
    resp_en = 1'b0;
    dmem_busy = 1'b1;
    store(32'h0000_6000, 32'h6666_6666, 4'b1111, 1'b0);
    store(32'h0000_6004, 32'h7777_7777, 4'b1111, 1'b0);
    dmem_busy = 1'b0;
    begin
      bit started;
      started = 1'b0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (dmem_write) begin
          started = 1'b1;
          break;
        end
      end
      chk("write_started", {31'b0, started}, 32'd1);
    end
    chk("inflight_addr", dmem_address, 32'h0000_6000);
    step();
    dmem_busy = 1'b1;
    @(negedge clk);
    chk("write_not_aborted", {31'b0, dmem_write}, 32'd1);
    chk("inflight_addr_held", dmem_address, 32'h0000_6000);
    step();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_dmem_write", {31'b0, dmem_write}, 32'd0);
    chk("midrst_empty", {31'b0, empty}, 32'd1);
    chk("midrst_st_ready", {31'b0, st_ready}, 32'd1);
    step();
    rst = 1'b0;
    exp_wr.delete();
    resp_en = 1'b1;
    dmem_busy = 1'b0;
    load(32'h0000_6000, 4'b1111, 1'b0, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    chk("post_rst_empty", {31'b0, empty}, 32'd1);
    chk("post_rst_no_write", {31'b0, dmem_write}, 32'd0);
    step();

    chk("writes_all_seen", exp_wr.size(), 32'd0);
    chk("loads_all_seen", exp_ld.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
